// File: rtl/data_unpacker.sv
// Wide-to-narrow width converter: holds one wide word and emits it as OUT_WIDTH slices
// over a req/ready handshake. Define DATA_UNPACKER_MSB_FIRST_EN to emit the top slice first.
module data_unpacker #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32,
    parameter int OP_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_write_req,
    output logic                 s_write_ready,
    input  logic [IN_WIDTH-1:0]  s_write_data,
    output logic                 m_write_req,
    input  logic                 m_write_ready,
    output logic [OUT_WIDTH-1:0] m_write_data
);

    function automatic int c_log_2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    localparam int OUT_NUM_RAW  = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int OUT_NUM_DATA = (OUT_NUM_RAW < 1) ? 1 : OUT_NUM_RAW;
    localparam int COUNT_LOG    = c_log_2(OUT_NUM_DATA);
    localparam int DATA_COUNT_W = (COUNT_LOG < 1) ? 1 : COUNT_LOG;
    localparam int PAD_WIDTH    = OUT_NUM_DATA * OUT_WIDTH;

    // Slices must carry a whole number of operands for the PE array.
    if ((OUT_WIDTH % OP_WIDTH) != 0) begin : g_bad_op_width
        $error("data_unpacker: OUT_WIDTH must be a multiple of OP_WIDTH");
    end

    if (OUT_NUM_DATA == 1) begin : g_pass
        assign m_write_req   = s_write_req;
        assign s_write_ready = m_write_ready;

        always_comb begin
            m_write_data                = '0;
            m_write_data[IN_WIDTH-1:0]  = s_write_data;
        end
    end else begin : g_unpack
        typedef enum logic {
            EMPTY = 1'b0,
            HOLD  = 1'b1
        } state_t;

        localparam logic [DATA_COUNT_W-1:0] LAST_IDX = DATA_COUNT_W'(OUT_NUM_DATA - 1);

        state_t                  state_q, state_d;
        logic [DATA_COUNT_W-1:0] dcount_q, dcount_d;
        logic [IN_WIDTH-1:0]     data_q, data_d;
        logic [PAD_WIDTH-1:0]    padded;
        logic [OUT_WIDTH-1:0]    slices [OUT_NUM_DATA];
        logic [DATA_COUNT_W-1:0] slice_idx;
        logic                    last_slice;
        logic                    in_xfer;
        logic                    out_xfer;

        assign last_slice    = (dcount_q == LAST_IDX);
        assign s_write_ready = (state_q == EMPTY) || (m_write_ready && last_slice);
        assign m_write_req   = (state_q == HOLD);
        assign in_xfer       = s_write_req && s_write_ready;
        assign out_xfer      = (state_q == HOLD) && m_write_ready;

        // A new word may be captured on the last-slice handoff, so consecutive words stream without a bubble.
        always_comb begin
            state_d  = state_q;
            dcount_d = dcount_q;
            data_d   = data_q;
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d  = HOLD;
                        dcount_d = '0;
                        data_d   = s_write_data;
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        if (!last_slice) begin
                            dcount_d = dcount_q + 1'b1;
                        end else if (in_xfer) begin
                            dcount_d = '0;
                            data_d   = s_write_data;
                        end else begin
                            state_d  = EMPTY;
                            dcount_d = '0;
                        end
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    dcount_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= EMPTY;
                dcount_q <= '0;
                data_q   <= '0;
            end else begin
                state_q  <= state_d;
                dcount_q <= dcount_d;
                data_q   <= data_d;
            end
        end

        // Bits above IN_WIDTH in the final slice read as zero.
        always_comb begin
            padded                 = '0;
            padded[IN_WIDTH-1:0]   = data_q;
            for (int k = 0; k < OUT_NUM_DATA; k++) begin
                slices[k] = padded[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end

`ifdef DATA_UNPACKER_MSB_FIRST_EN
        assign slice_idx = LAST_IDX - dcount_q;
`else
        assign slice_idx = dcount_q;
`endif

        assign m_write_data = slices[slice_idx];
    end

endmodule
